// File: rtl/code3to8_framer.sv
// code3to8_framer: packs 3-bit codes into an 8-bit one-hot frame mask.
// Optional seven-segment count display: define CODE3TO8_SEG_EN.
module code3to8_framer #(
  parameter bit HOLD_MASK = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_mask,
  output logic [3:0] out_count,
  output logic       out_dup
`ifdef CODE3TO8_SEG_EN
  ,
  output logic [6:0] seg_n
`endif
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t     state;
  state_t     state_nx;
  logic       live;
  logic [7:0] acc;
  logic [7:0] acc_nx;
  logic [7:0] bit_sel;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic       dup;
  logic       dup_nx;
  logic       hit;
  logic       take;
  logic       drain;

  assign bit_sel   = 8'h01 << in_code;
  assign hit       = |(acc & bit_sel);
  assign acc_nx    = acc | bit_sel;
  assign cnt_nx    = cnt + {3'b000, ~hit};
  assign dup_nx    = dup | hit;
  assign out_valid = (state == HOLD);
  assign in_ready  = live & ((state == ACCUM) | out_ready);
  assign take      = in_valid & in_ready;
  assign drain     = (state == HOLD) & out_ready;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nx;
  end

  // next state: a last beat always presents a frame, a handshake releases it
  always_comb begin
    state_nx = state;
    if (take && in_last) state_nx = HOLD;
    else if (drain)      state_nx = ACCUM;
  end

  // accumulator and output frame registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live      <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      dup       <= 1'b0;
      out_mask  <= '0;
      out_count <= '0;
      out_dup   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (drain && !HOLD_MASK) out_mask <= '0;
      if (take) begin
        if (in_last) begin
          out_mask  <= acc_nx;
          out_count <= cnt_nx;
          out_dup   <= dup_nx;
          acc       <= '0;
          cnt       <= '0;
          dup       <= 1'b0;
        end else begin
          acc <= acc_nx;
          cnt <= cnt_nx;
          dup <= dup_nx;
        end
      end
    end
  end

`ifdef CODE3TO8_SEG_EN
  // active-low digit decode of the count, blank when no frame is shown
  always_comb begin
    seg_n = 7'h7F;
    if (out_valid) begin
      case (out_count)
        4'd0:    seg_n = 7'b1000000;
        4'd1:    seg_n = 7'b1111001;
        4'd2:    seg_n = 7'b0100100;
        4'd3:    seg_n = 7'b0110000;
        4'd4:    seg_n = 7'b0011001;
        4'd5:    seg_n = 7'b0010010;
        4'd6:    seg_n = 7'b0000010;
        4'd7:    seg_n = 7'b1111000;
        4'd8:    seg_n = 7'b0000000;
        default: seg_n = 7'h7F;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_code3to8_framer.sv
// tb_code3to8_framer: directed vectors against two instances,
// one holding the mask after release and one clearing it.
module tb_code3to8_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = 3'd0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_dup;
  logic [7:0] out_mask;
  logic [3:0] out_count;
  logic       in_ready0, out_valid0, out_dup0;
  logic [7:0] out_mask0;
  logic [3:0] out_count0;
`ifdef CODE3TO8_SEG_EN
  logic [6:0] seg_n, seg_n0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  code3to8_framer #(.HOLD_MASK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mask(out_mask), .out_count(out_count),
    .out_dup(out_dup)
`ifdef CODE3TO8_SEG_EN
    , .seg_n(seg_n)
`endif
  );

  code3to8_framer #(.HOLD_MASK(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_code(in_code), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_mask(out_mask0), .out_count(out_count0),
    .out_dup(out_dup0)
`ifdef CODE3TO8_SEG_EN
    , .seg_n(seg_n0)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic frame(input string tag, input logic v,
                       input logic [7:0] m1, input logic [7:0] m0,
                       input logic [3:0] c, input logic d);
    check({tag, ".valid"},  {31'd0, out_valid}, {31'd0, v});
    check({tag, ".valid0"}, {31'd0, out_valid0}, {31'd0, v});
    check({tag, ".mask"},   {24'd0, out_mask}, {24'd0, m1});
    check({tag, ".mask0"},  {24'd0, out_mask0}, {24'd0, m0});
    check({tag, ".count"},  {28'd0, out_count}, {28'd0, c});
    check({tag, ".count0"}, {28'd0, out_count0}, {28'd0, c});
    check({tag, ".dup"},    {31'd0, out_dup}, {31'd0, d});
    check({tag, ".dup0"},   {31'd0, out_dup0}, {31'd0, d});
  endtask

  task automatic beat(input logic [2:0] code, input logic last);
    in_valid = 1'b1;
    in_code  = code;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    frame("rst", 1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
    check("rst.ready", {31'd0, in_ready}, 32'd0);
    check("rst.ready0", {31'd0, in_ready0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel.ready_low", {31'd0, in_ready}, 32'd0);
    idle();
    check("rel.ready_up", {31'd0, in_ready}, 32'd1);
    check("rel.ready_up0", {31'd0, in_ready0}, 32'd1);

    out_ready = 1'b1;
    beat(3'd0, 1'b0);
    beat(3'd3, 1'b0);
    check("f1.accum", {31'd0, out_valid}, 32'd0);
    beat(3'd7, 1'b1);
    frame("f1", 1'b1, 8'h89, 8'h89, 4'd3, 1'b0);
    idle();
    frame("f1.rel", 1'b0, 8'h89, 8'h00, 4'd3, 1'b0);

    out_ready = 1'b0;
    beat(3'd5, 1'b0);
    beat(3'd5, 1'b0);
    beat(3'd2, 1'b1);
    frame("f2", 1'b1, 8'h24, 8'h24, 4'd2, 1'b1);
    in_valid = 1'b1;
    in_code  = 3'd1;
    in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      check("stall.ready", {31'd0, in_ready}, 32'd0);
      frame("stall", 1'b1, 8'h24, 8'h24, 4'd2, 1'b1);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    idle();
    frame("f2.rel", 1'b0, 8'h24, 8'h00, 4'd2, 1'b1);

    out_ready = 1'b0;
    beat(3'd1, 1'b1);
    frame("f3", 1'b1, 8'h02, 8'h02, 4'd1, 1'b0);
    out_ready = 1'b1;
    beat(3'd6, 1'b1);
    frame("b2b", 1'b1, 8'h40, 8'h40, 4'd1, 1'b0);
    idle();
    check("b2b.rel", {31'd0, out_valid}, 32'd0);

    out_ready = 1'b0;
    beat(3'd4, 1'b1);
    frame("f4", 1'b1, 8'h10, 8'h10, 4'd1, 1'b0);
    out_ready = 1'b1;
    beat(3'd3, 1'b0);
    frame("f4.rel", 1'b0, 8'h10, 8'h00, 4'd1, 1'b0);
    idle();
    beat(3'd3, 1'b1);
    frame("dup1", 1'b1, 8'h08, 8'h08, 4'd1, 1'b1);
    idle();

    beat(3'd1, 1'b0);
    beat(3'd4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    frame("mrst", 1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
    check("mrst.ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    beat(3'd2, 1'b1);
    frame("f5", 1'b1, 8'h04, 8'h04, 4'd1, 1'b0);

    out_ready = 1'b0;
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    frame("hrst", 1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    out_ready = 1'b1;
`ifdef CODE3TO8_SEG_EN
    check("seg.blank", {25'd0, seg_n}, 32'h7F);
`endif
    for (int i = 0; i < 7; i++) beat(3'(i), 1'b0);
    beat(3'd7, 1'b1);
    frame("f8", 1'b1, 8'hFF, 8'hFF, 4'd8, 1'b0);
`ifdef CODE3TO8_SEG_EN
    check("seg.8", {25'd0, seg_n}, 32'h00);
`endif
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/code3to8_framer.md
CODE3TO8_FRAMER -- requirements
Module: code3to8_framer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter HOLD_MASK, default 1, SHALL select behaviour after output handshake: 1 = out_mask keeps the last frame; 0 = out_mask clears to 8'h00.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  in_code/in_last are valid this cycle.
REQ-006 in_ready  output  1  block accepts a code this cycle.
REQ-007 in_code  input  3  bit position 0..7 to set in the frame.
REQ-008 in_last  input  1  accepted code is the final code of the frame.
REQ-009 out_valid  output  1  out_mask/out_count/out_dup hold a completed frame.
REQ-010 out_ready  input  1  consumer takes the frame this cycle.
REQ-011 out_mask  output  8  one-hot OR of all codes in the frame (bit n set for code n).
REQ-012 out_count  output  4  number of distinct bits set in out_mask, 0..8.
REQ-013 out_dup  output  1  frame contained at least one repeated code.

Function
REQ-014 An input beat SHALL be accepted only when in_valid and in_ready are both 1.
REQ-015 The FSM SHALL have two states: ACCUM (collecting codes) and HOLD (frame presented).
REQ-016 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-017 In HOLD, out_valid SHALL be 1 and in_ready SHALL equal out_ready.
REQ-018 An accepted beat SHALL OR (1 << in_code) into an internal accumulator.
REQ-019 An accepted beat SHALL increment the distinct counter only if that bit was clear; otherwise it SHALL set the dup flag.
REQ-020 An accepted beat with in_last=1 SHALL load out_mask, out_count and out_dup from the updated accumulator, counter and flag on the same edge.
REQ-021 That beat SHALL also clear the accumulator, counter and flag, and the FSM SHALL enter HOLD.
REQ-022 Latency SHALL be 1 cycle: out_valid rises on the clock edge that accepts the last beat.
REQ-023 A single-beat frame (first beat has in_last=1) SHALL produce a frame with count 1 and dup 0.
REQ-024 In HOLD, with out_ready=1 and no accepted beat, the FSM SHALL return to ACCUM on that edge.
REQ-025 In that case, out_mask SHALL hold if HOLD_MASK=1 and clear to 0 if HOLD_MASK=0.
REQ-026 Simultaneous handshake in HOLD with an accepted in_last=0 beat SHALL release the frame, start a new accumulation containing that code, and enter ACCUM.
REQ-027 Simultaneous handshake in HOLD with an accepted in_last=1 beat SHALL release the frame and load a new single-code frame, with no idle cycle, and SHALL stay in HOLD.
REQ-028 Output registers SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 The distinct counter SHALL never exceed 8; it needs no wrap handling.
REQ-030 Beats with in_valid=0 SHALL not alter any state.

Reset
REQ-031 Assertion of rst_n=0 SHALL asynchronously force: FSM to ACCUM; accumulator to 8'h00; counter to 0; dup flag to 0.
REQ-032 The same reset SHALL force: out_valid=0, out_mask=8'h00, out_count=0, out_dup=0, in_ready=0.
REQ-033 in_ready SHALL rise to 1 on the first clock edge after rst_n deasserts.
REQ-034 Reset in mid-frame or in HOLD SHALL discard the partial or presented frame with no output.

Configuration
REQ-035 With macro CODE3TO8_SEG_EN defined, the block SHALL add output seg_n (7 bits, active-low, segments a..g = bits 0..6).
REQ-036 seg_n SHALL show the decimal digit out_count (0..8), and SHALL be all-ones (blank) while out_valid=0.
REQ-037 Without CODE3TO8_SEG_EN, the seg_n port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 Codes 0,3,7(last), out_ready=1 -> one cycle after the last beat: out_valid=1, out_mask=8'h89, out_count=3, out_dup=0.
REQ-039 Codes 5,5,2(last) -> out_mask=8'h24, out_count=2, out_dup=1.
REQ-040 Frame completes with out_ready=0 for 4 cycles -> outputs stable, in_ready=0, and in_valid beats are ignored; then out_ready=1 -> ACCUM next cycle, with out_mask held (HOLD_MASK=1) or 8'h00 (HOLD_MASK=0).
REQ-041 In HOLD, out_ready=1 together with code 6 (last) -> out_valid stays 1, out_mask=8'h40, out_count=1.
REQ-042 rst_n pulsed low after codes 1,4 (no last), then code 2 (last) -> out_mask=8'h04, out_count=1.
REQ-043 With CODE3TO8_SEG_EN, an 8-distinct-code frame -> out_mask=8'hFF, out_count=8, seg_n = digit "8" (7'b0000000).
